// File: rtl/aes_pkg.sv
// Shared types and sizes for the AES byte bridge.
package aes_pkg;

  localparam int AES_BLK_BITS  = 128;
  localparam int AES_BLK_BYTES = 16;

  typedef logic [AES_BLK_BITS-1:0] aes_blk_t;

  typedef enum logic [2:0] {FILL, LOAD, REQ, WAIT, DRAIN} bridge_state_t;

endpackage

// File: rtl/aes_byte_bridge_shifter.sv
// 128-bit byte-wide shift register with a 4-bit byte counter; load has priority over shift.
module aes_byte_shifter
  import aes_pkg::*;
(
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    load,
  input  logic [AES_BLK_BITS-1:0] load_data,
  input  logic                    shift,
  input  logic [7:0]              shift_in,
  output logic [AES_BLK_BITS-1:0] blk_q,
  output logic [3:0]              cnt_q
);

  logic [AES_BLK_BITS-1:0] blk_d;
  logic [3:0]              cnt_d;

  always_comb begin
    blk_d = blk_q;
    cnt_d = cnt_q;
    if (load) begin
      blk_d = load_data;
      cnt_d = 4'd0;
    end else if (shift) begin
      blk_d = {blk_q[AES_BLK_BITS-9:0], shift_in};
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      blk_q <= '0;
      cnt_q <= 4'd0;
    end else begin
      blk_q <= blk_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/aes_byte_bridge.sv
// Byte-stream front/back end for AES_Block: gathers 16 bytes, runs one block, drains 16 bytes.
//   state | meaning
//   FILL  | accepting input bytes into the assembly buffer
//   LOAD  | aes_enable pulse; key and block already presented
//   REQ   | aes_enc_req or aes_dec_req pulse
//   WAIT  | waiting for aes_data_ready under the watchdog
//   DRAIN | serialising the captured result, MSB byte first
module aes_byte_bridge
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 127
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         mode,
  input  logic [127:0] key,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [7:0]   out_data,
  input  logic         out_ready,
  output logic         aes_enable,
  output logic         aes_enc_req,
  output logic         aes_dec_req,
  output logic [127:0] aes_key,
  output logic [127:0] aes_data_in,
  input  logic [127:0] aes_data_out,
  input  logic         aes_data_ready,
  output logic         busy,
  output logic         timeout_err
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  bridge_state_t   state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            mode_q, mode_d;
  logic [127:0]    key_q, key_d;
  logic [127:0]    obuf_q, obuf_d;
  logic [3:0]      ocnt_q, ocnt_d;
  logic            terr_q, terr_d;
  logic            en_q, en_d;
  logic            enc_q, enc_d;
  logic            dec_q, dec_d;
  logic            busy_q, busy_d;
  logic            in_shift;
  logic [3:0]      icnt_q, icnt_d;
  logic [127:0]    ibuf_q;

  aes_byte_shifter u_in_shifter (
    .clk       (clk),
    .n_rst     (n_rst),
    .load      (1'b0),
    .load_data ('0),
    .shift     (in_shift),
    .shift_in  (in_data),
    .blk_q     (ibuf_q),
    .cnt_q     (icnt_q)
  );

  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    mode_d   = mode_q;
    key_d    = key_q;
    obuf_d   = obuf_q;
    ocnt_d   = ocnt_q;
    terr_d   = terr_q;
    in_shift = 1'b0;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          in_shift = 1'b1;
          if (icnt_q == 4'd0) begin
            mode_d = mode;
            key_d  = key;
            terr_d = 1'b0;
          end
          if (icnt_q == 4'd15) state_d = LOAD;
        end
      end
      LOAD: state_d = REQ;
      REQ: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A result arriving on the last watchdog cycle still counts.
        if (aes_data_ready) begin
          obuf_d  = aes_data_out;
          ocnt_d  = 4'd0;
          state_d = DRAIN;
        end else if (wd_q == WD_LAST) begin
          terr_d  = 1'b1;
          state_d = FILL;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          obuf_d = {obuf_q[119:0], 8'h00};
          ocnt_d = ocnt_q + 4'd1;
          if (ocnt_q == 4'd15) state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    icnt_d = icnt_q + {3'b000, in_shift};
    en_d   = (state_d == LOAD);
    enc_d  = (state_d == REQ) && !mode_d;
    dec_d  = (state_d == REQ) && mode_d;
    busy_d = (state_d != FILL) || (icnt_d != 4'd0);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= FILL;
      wd_q    <= '0;
      mode_q  <= 1'b0;
      key_q   <= '0;
      obuf_q  <= '0;
      ocnt_q  <= 4'd0;
      terr_q  <= 1'b0;
      en_q    <= 1'b0;
      enc_q   <= 1'b0;
      dec_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      mode_q  <= mode_d;
      key_q   <= key_d;
      obuf_q  <= obuf_d;
      ocnt_q  <= ocnt_d;
      terr_q  <= terr_d;
      en_q    <= en_d;
      enc_q   <= enc_d;
      dec_q   <= dec_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready    = (state_q == FILL);
  assign out_valid   = (state_q == DRAIN);
  assign out_data    = obuf_q[127:120];
  assign aes_enable  = en_q;
  assign aes_enc_req = enc_q;
  assign aes_dec_req = dec_q;
  assign aes_key     = key_q;
  assign aes_data_in = ibuf_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_aes_byte_bridge.sv
// Self-checking bench for aes_byte_bridge with a behavioural stand-in for AES_Block.
module tb_aes_byte_bridge;
  import aes_pkg::*;

  localparam int TO = 127;
  localparam logic [127:0] K = 128'h5e74e7ba66b0c7cc1b7697b3f9f51527;

  logic clk = 1'b0, n_rst = 1'b0, mode = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [127:0] key = '0, aes_data_out = '0, aes_key, aes_data_in;
  logic [7:0] in_data = '0, out_data;
  logic in_ready, out_valid, aes_enable, aes_enc_req, aes_dec_req, busy, timeout_err;
  logic aes_data_ready = 1'b0;

  int total = 0, bad = 0;
  int or_mode = 0;

  aes_byte_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .n_rst(n_rst), .mode(mode), .key(key),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .aes_enable(aes_enable), .aes_enc_req(aes_enc_req), .aes_dec_req(aes_dec_req),
    .aes_key(aes_key), .aes_data_in(aes_data_in), .aes_data_out(aes_data_out),
    .aes_data_ready(aes_data_ready), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Stand-in block cipher: an invertible mix of block and key, distinct per direction.
  function automatic logic [127:0] xform(input logic dec, input logic [127:0] d, input logic [127:0] k);
    xform = dec ? (d ^ ~k) : ({d[63:0], d[127:64]} ^ k);
  endfunction

  // ---------------- stub AES_Block ----------------
  int stub_lat = 0;
  bit stub_never = 0, stub_fixed_en = 0;
  logic [127:0] stub_fixed = '0, s_key = '0, s_data = '0;
  logic s_busy = 1'b0, s_dec = 1'b0;
  int s_cnt = 0;

  always @(posedge clk) begin
    aes_data_ready <= 1'b0;
    if (!n_rst) s_busy <= 1'b0;
    else begin
      if (aes_enable) begin
        s_key  <= aes_key;
        s_data <= aes_data_in;
      end
      if (aes_enc_req || aes_dec_req) begin
        s_busy <= 1'b1;
        s_cnt  <= stub_lat;
        s_dec  <= aes_dec_req;
      end else if (s_busy) begin
        if (s_cnt == 0) begin
          s_busy <= 1'b0;
          if (!stub_never) begin
            aes_data_ready <= 1'b1;
            aes_data_out   <= stub_fixed_en ? stub_fixed : xform(s_dec, s_data, s_key);
          end
        end else s_cnt <= s_cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- monitor ----------------
  int cyc = 0;
  int en_q[$], enc_q[$], dec_q[$], ov_q[$], terr_q[$];
  logic [7:0] out_bytes[$];
  logic prev_hold = 1'b0, prev_ov = 1'b0, prev_terr = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (aes_enable)  en_q.push_back(cyc);
    if (aes_enc_req) enc_q.push_back(cyc);
    if (aes_dec_req) dec_q.push_back(cyc);
    if (out_valid && !prev_ov) ov_q.push_back(cyc);
    if (timeout_err && !prev_terr) terr_q.push_back(cyc);
    if (out_valid && out_ready) out_bytes.push_back(out_data);
    if (prev_hold) begin
      total++;
      if (!out_valid || out_data !== prev_data) begin
        bad++;
        $display("FAIL hold: got valid=%b data=%h want valid=1 data=%h", out_valid, out_data, prev_data);
      end
    end
    prev_hold = out_valid && !out_ready && n_rst;
    prev_data = out_data;
    prev_ov   = out_valid;
    prev_terr = timeout_err;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    en_q.delete(); enc_q.delete(); dec_q.delete();
    ov_q.delete(); terr_q.delete(); out_bytes.delete();
  endtask

  task automatic push_byte(input logic m, input logic [127:0] k, input logic [7:0] b);
    bit acc = 0;
    int guard = 0;
    in_valid = 1'b1; in_data = b; mode = m; key = k;
    do begin
      acc = in_ready;
      step();
      guard++;
    end while (!acc && guard < 300);
    in_valid = 1'b0;
    mode = ~m; key = ~k;
    if (!acc) chk("in_accept", 0, 1);
  endtask

  task automatic push_block(input logic m, input logic [127:0] k, input logic [127:0] d,
                            input int first, input int max_gap);
    for (int i = first; i < AES_BLK_BYTES; i++) begin
      repeat ($urandom_range(0, max_gap)) step();
      push_byte(m, k, d[127-8*i -: 8]);
    end
    chk("load_en", aes_enable, 1);
    chk("load_key", aes_key, k);
    chk("load_data", aes_data_in, d);
  endtask

  task automatic finish_block(input string nm, input logic m, input logic [127:0] exp);
    logic [127:0] got = '0;
    int guard = 0;
    while (out_bytes.size() < AES_BLK_BYTES && guard < 600) begin
      step();
      guard++;
    end
    repeat (3) step();
    chk_int({nm, "_nbytes"}, out_bytes.size(), AES_BLK_BYTES);
    foreach (out_bytes[i]) got = {got[119:0], out_bytes[i]};
    chk({nm, "_block"}, got, exp);
    chk_int({nm, "_en"}, en_q.size(), 1);
    chk_int({nm, "_enc"}, enc_q.size(), m ? 0 : 1);
    chk_int({nm, "_dec"}, dec_q.size(), m ? 1 : 0);
    if (en_q.size() == 1 && (enc_q.size() + dec_q.size()) == 1)
      chk_int({nm, "_req_after_en"}, m ? dec_q[0] : enc_q[0], en_q[0] + 1);
    chk({nm, "_idle"}, {busy, in_ready, out_valid}, 3'b010);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
  endtask

  typedef struct {
    logic         m;
    logic [127:0] k;
    logic [127:0] data;
    int           lat;
    logic [127:0] exp_blk;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [127:0] d, kk;
    logic mm;
    int guard;

    vecs[0] = '{1'b0, K, 128'h000102030405060708090a0b0c0d0e0f, 10, 128'hdeb0f81341f3503a7cd01e2bc7cdd556};
    vecs[1] = '{1'b1, K, 128'hdeb0f81341f3503a7cd01e2bc7cdd556, 75, 128'h00112233445566778899aabbccddeeff};
    vecs[2] = '{1'b0, '0, {128{1'b1}}, 0, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0};
    vecs[3] = '{1'b1, {128{1'b1}}, '0, 100, {16{8'ha5}}};

    // reset state
    n_rst = 1'b0;
    step();
    chk("rst_outs", {in_ready, out_valid, aes_enable, aes_enc_req, aes_dec_req, busy, timeout_err}, 7'b1000000);
    chk("rst_regs", {aes_key ^ aes_data_in, out_data}, '0);
    n_rst = 1'b1;
    step();

    // table vectors, stub returns a fixed result
    stub_fixed_en = 1;
    for (int v = 0; v < 4; v++) begin
      clear_q();
      stub_fixed = vecs[v].exp_blk;
      stub_lat   = vecs[v].lat;
      push_block(vecs[v].m, vecs[v].k, vecs[v].data, 0, v);
      finish_block("tbl", vecs[v].m, vecs[v].exp_blk);
      if (ov_q.size() > 0 && en_q.size() > 0)
        chk_int("tbl_latency", ov_q[0] - en_q[0], vecs[v].lat + 4);
      else
        chk_int("tbl_latency_seen", 0, 1);
    end

    // backpressure: toggled out_ready
    clear_q();
    stub_fixed = 128'h00112233445566778899aabbccddeeff;
    stub_lat = 20;
    or_mode = 1;
    push_block(1'b0, K, 128'h0123456789abcdeffedcba9876543210, 0, 0);
    finish_block("bp", 1'b0, 128'h00112233445566778899aabbccddeeff);
    or_mode = 0;

    // watchdog timeout
    clear_q();
    stub_never = 1;
    push_block(1'b0, K, 128'h55, 0, 0);
    guard = 0;
    while (terr_q.size() == 0 && guard < 400) begin
      step();
      guard++;
    end
    chk_int("to_seen", terr_q.size(), 1);
    if (terr_q.size() > 0 && enc_q.size() > 0) chk_int("to_cycle", terr_q[0] - enc_q[0], TO + 1);
    chk("to_state", {timeout_err, in_ready, busy, out_valid}, 4'b1100);
    repeat (5) step();
    chk_int("to_no_out", out_bytes.size(), 0);
    stub_never = 0;

    // next block's byte 0 clears timeout_err
    stub_fixed_en = 0;
    clear_q();
    d = {$urandom, $urandom, $urandom, $urandom};
    stub_lat = 30;
    push_byte(1'b1, K, d[127:120]);
    chk("to_clear", {timeout_err, busy}, 2'b01);
    push_block(1'b1, K, d, 1, 0);
    finish_block("to_next", 1'b1, xform(1'b1, d, K));

    // reset during WAIT
    clear_q();
    stub_lat = 80;
    push_block(1'b0, K, d, 0, 0);
    repeat (10) step();
    chk("mid_wait_busy", {busy, in_ready}, 2'b10);
    do_reset();
    chk("mid_wait_rst", {out_valid, in_ready, busy}, 3'b010);

    // reset during DRAIN byte 5
    clear_q();
    stub_lat = 5;
    push_block(1'b1, ~K, d, 0, 0);
    guard = 0;
    while (out_bytes.size() < 5 && guard < 200) begin
      step();
      guard++;
    end
    chk("mid_drain_valid", out_valid, 1);
    do_reset();
    chk("mid_drain_rst", {out_valid, in_ready, busy}, 3'b010);
    repeat (100) step();
    clear_q();
    d = {$urandom, $urandom, $urandom, $urandom};
    stub_lat = 12;
    push_block(1'b0, K, d, 0, 1);
    finish_block("post_rst", 1'b0, xform(1'b0, d, K));

    // randomized blocks against the reference model
    or_mode = 2;
    for (int n = 0; n < 20; n++) begin
      clear_q();
      mm = 1'($urandom_range(0, 1));
      kk = {$urandom, $urandom, $urandom, $urandom};
      d  = {$urandom, $urandom, $urandom, $urandom};
      stub_lat = $urandom_range(0, 100);
      push_block(mm, kk, d, 0, 2);
      finish_block("rnd", mm, xform(mm, d, kk));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
